// File: rtl/furv_pkg.sv
// Shared furv definitions for the memory arbiter: state and owner encodings
// and the default parameters.
package furv_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_t;

  typedef enum logic {
    OWN_FETCH = 1'b0,
    OWN_DATA  = 1'b1
  } arb_owner_t;

  localparam int unsigned DEF_MEM_LATENCY  = 2;
  localparam int unsigned DEF_STARVE_LIMIT = 4;
  localparam int unsigned DEF_AW           = 32;

endpackage

// File: rtl/furv_mem_arbiter_if.sv
// Bundle of the fetch, load/store and unified-memory signals around the arbiter.
// The slave modport is the arbiter's view; master is the core/memory side.
interface furv_mem_arbiter_if #(
  parameter int unsigned AW = furv_pkg::DEF_AW
) ();

  logic          i_req;
  logic [AW-1:0] i_addr;
  logic          i_ready;
  logic          i_rvalid;
  logic [31:0]   i_rdata;

  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [31:0]   d_wdata;
  logic [3:0]    d_wstrb;
  logic          d_ready;
  logic          d_rvalid;
  logic [31:0]   d_rdata;

  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [3:0]    mem_wstrb;
  logic [31:0]   mem_rdata;

  modport slave (
    input  i_req, i_addr,
    output i_ready, i_rvalid, i_rdata,
    input  d_req, d_we, d_addr, d_wdata, d_wstrb,
    output d_ready, d_rvalid, d_rdata,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    input  mem_rdata
  );

  modport master (
    output i_req, i_addr,
    input  i_ready, i_rvalid, i_rdata,
    output d_req, d_we, d_addr, d_wdata, d_wstrb,
    input  d_ready, d_rvalid, d_rdata,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    output mem_rdata
  );

endinterface

// File: rtl/furv_mem_arbiter.sv
// Arbitrates the furv fetch and load/store ports onto one fixed-latency memory,
// one transaction in flight, data first with a starvation escape for fetch.
module furv_mem_arbiter
  import furv_pkg::*;
#(
  parameter int unsigned MEM_LATENCY  = DEF_MEM_LATENCY,
  parameter int unsigned STARVE_LIMIT = DEF_STARVE_LIMIT,
  parameter int unsigned AW           = DEF_AW
) (
  input  logic              clk,
  input  logic              rst,
  furv_mem_arbiter_if.slave bus
);

  localparam int unsigned CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] CNT_INIT   = CW'(MEM_LATENCY - 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  arb_state_t    state_q, state_n;
  arb_owner_t    owner_q, owner_n;
  logic          we_q, we_n;
  logic [CW-1:0] cnt_q, cnt_n;
  logic [SW-1:0] starve_q, starve_n;

  logic          grant_window;
  logic          resp;
  logic          pick_fetch;
  logic [AW-1:0] addr_sel;

  // A grant may happen when idle or in the last busy cycle (back-to-back).
  assign grant_window = !rst && ((state_q == ARB_IDLE) ||
                                 ((state_q == ARB_BUSY) && (cnt_q == '0)));
  assign resp         = !rst && (state_q == ARB_BUSY) && (cnt_q == '0);
  assign pick_fetch   = bus.i_req && (!bus.d_req || (starve_q == STARVE_MAX));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ARB_IDLE;
      owner_q  <= OWN_FETCH;
      we_q     <= 1'b0;
      cnt_q    <= '0;
      starve_q <= '0;
    end else begin
      state_q  <= state_n;
      owner_q  <= owner_n;
      we_q     <= we_n;
      cnt_q    <= cnt_n;
      starve_q <= starve_n;
    end
  end

  always_comb begin
    state_n       = state_q;
    owner_n       = owner_q;
    we_n          = we_q;
    cnt_n         = cnt_q;
    starve_n      = starve_q;
    addr_sel      = '0;
    bus.i_ready   = 1'b0;
    bus.i_rvalid  = 1'b0;
    bus.i_rdata   = 32'h0;
    bus.d_ready   = 1'b0;
    bus.d_rvalid  = 1'b0;
    bus.d_rdata   = 32'h0;
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_wdata = 32'h0;
    bus.mem_wstrb = 4'h0;

    // Response for the transaction that is completing this cycle.
    if (resp) begin
      if (owner_q == OWN_FETCH) begin
        bus.i_rvalid = 1'b1;
        bus.i_rdata  = bus.mem_rdata;
      end else begin
        bus.d_rvalid = 1'b1;
        bus.d_rdata  = we_q ? 32'h0 : bus.mem_rdata;
      end
    end

    if (state_q == ARB_BUSY) begin
      if (cnt_q != '0) begin
        cnt_n = cnt_q - CW'(1);
      end else begin
        state_n = ARB_IDLE;
      end
    end

    if (!bus.i_req) begin
      starve_n = '0;
    end

    if (grant_window && pick_fetch) begin
      bus.i_ready = 1'b1;
      bus.mem_req = 1'b1;
      addr_sel    = bus.i_addr;
      owner_n     = OWN_FETCH;
      we_n        = 1'b0;
      state_n     = ARB_BUSY;
      cnt_n       = CNT_INIT;
      starve_n    = '0;
    end else if (grant_window && bus.d_req) begin
      bus.d_ready   = 1'b1;
      bus.mem_req   = 1'b1;
      bus.mem_we    = bus.d_we;
      bus.mem_wdata = bus.d_wdata;
      bus.mem_wstrb = bus.d_wstrb;
      addr_sel      = bus.d_addr;
      owner_n       = OWN_DATA;
      we_n          = bus.d_we;
      state_n       = ARB_BUSY;
      cnt_n         = CNT_INIT;
      // Saturating count of data grants taken while fetch is waiting.
      if (!bus.i_req) begin
        starve_n = '0;
      end else if (starve_q != STARVE_MAX) begin
        starve_n = starve_q + SW'(1);
      end
    end

    bus.mem_addr = addr_sel;
  end

endmodule
